// File: rtl/bram_stream_reader.sv
// bram_stream_reader: read-side sequencer for a simple dual-port BRAM.
// A start command walks a wrap-around address range on the BRAM read port.
// Each returned word is presented on a valid/ready stream. A 3-entry FIFO
// absorbs the one-cycle BRAM latency, so the block sustains one beat per
// cycle and loses nothing under backpressure.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, base_addr,     command strobe plus its first address and word
//   count                 count (0..BRAM_DEPTH), sampled only in idle
//   busy, done            command in progress; one-cycle completion pulse
//   re, addrout, dout     BRAM read port (dout valid the cycle after re)
//   out_data, out_valid,  output stream; out_last marks the final beat
//   out_ready, out_last
module bram_stream_reader #(
  parameter int unsigned BRAM_WIDTH = 32,
  parameter int unsigned BRAM_DEPTH = 256,
  localparam int unsigned AW = $clog2(BRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           count,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [AW-1:0]         addrout,
  input  logic [BRAM_WIDTH-1:0] dout,
  output logic [BRAM_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW:0]     issue_left_q, issue_left_d;
  logic [AW:0]     beat_left_q, beat_left_d;
  logic            done_q, done_d;
  logic            re_d_q;  // read issued last cycle; its data is on dout now

  logic [BRAM_WIDTH-1:0] mem_q [3];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  logic push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue only while the FIFO plus the in-flight read leaves room for one more
  // word; this uses registered state only, so re never depends on out_ready.
  assign re = (state_q == StRead) && (issue_left_q != '0) &&
              ((3'(fifo_cnt_q) + 3'(re_d_q)) <= 3'd2);
  assign addrout = rd_addr_q;

  assign push      = re_d_q;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && (beat_left_q == (AW+1)'(1));

  assign busy = (state_q != StIdle);
  assign done = done_q;

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    done_d       = 1'b0;

    if (pop) begin
      beat_left_d = beat_left_q - (AW+1)'(1);
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          rd_addr_d    = base_addr;
          issue_left_d = count;
          beat_left_d  = count;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (re) begin
          rd_addr_d    = (rd_addr_q == AW'(BRAM_DEPTH - 1)) ? '0 : rd_addr_q + AW'(1);
          issue_left_d = issue_left_q - (AW+1)'(1);
          if (issue_left_q == (AW+1)'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && (beat_left_q == (AW+1)'(1))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      done_q       <= 1'b0;
      re_d_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      done_q       <= done_d;
      re_d_q       <= re;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage needs no reset: out_data is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dout;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side sequencer for the simple dual-port block RAM used throughout the NoC (synaptic weight and spike buffers). On a start command it walks a contiguous, wrap-around address range on the BRAM read port (`re`/`addrout`, one-cycle registered-address latency) and presents each word as a valid/ready stream toward the router/neuron core. An internal 3-entry FIFO absorbs the BRAM latency, so the block sustains one word per cycle under full downstream readiness and loses no data under backpressure.

## Interface
- `BRAM_WIDTH`, 32, data word width; must match the attached BRAM.
- `BRAM_DEPTH`, 256, BRAM word count; AW = $clog2(BRAM_DEPTH).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: command strobe, sampled only in IDLE.
- `base_addr` in AW: first address, sampled with `start`.
- `count` in AW+1: words to read, 0..BRAM_DEPTH, sampled with `start`.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse at command completion.
- `re` out 1: BRAM read enable.
- `addrout` out AW: BRAM read address.
- `dout` in BRAM_WIDTH: BRAM read data, valid the cycle after `re`.
- `out_data` out BRAM_WIDTH: stream data.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready; beat transfers when valid & ready.
- `out_last` out 1: marks final beat of the command.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: `start`=1 latches base_addr→rd_addr, count→issue_left and beat_left. count≠0 → READ; count=0 → stays IDLE, `done` pulses next cycle, no reads, no beats.
- READ: `re`=1 iff issue_left≠0 and (fifo_count + re_d) ≤ 2, where re_d = registered `re`. On issue: `addrout`=rd_addr, rd_addr+1 modulo BRAM_DEPTH (BRAM_DEPTH-1 wraps to 0), issue_left-1. issue_left reaching 0 → DRAIN.
- Push: when re_d=1, `dout` written into FIFO at the end of that cycle. FIFO never overflows under the issue rule (max occupancy 3).
- Pop: FIFO head drives `out_data`; `out_valid` = fifo_count≠0. Valid & ready pops one entry and decrements beat_left. `out_last` = `out_valid` & (beat_left==1).
- Data must not change while `out_valid`=1 and `out_ready`=0.
- Simultaneous push and pop: count unchanged, order preserved.
- DRAIN: no reads; when the last beat transfers → IDLE, `done`=1 for exactly the next cycle.
- `busy`=1 in READ and DRAIN; 0 in IDLE (including the `done` cycle).
- `start` while busy is ignored.
- `re` must not depend combinationally on `out_ready`.
- `rst` mid-command: immediately IDLE, FIFO emptied, counters cleared, outstanding BRAM read discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `re`=0, `addrout`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- `start` sampled at edge 0 → cycle 1: `re`=1, `addrout`=base; cycle 2: `dout` pushed; cycle 3: first `out_valid`=1.
- With `out_ready` held 1: one beat per cycle; N-word command has last beat in cycle N+2; `done` in cycle N+3; next `start` accepted in cycle N+3.
- Steady state under full ready: fifo_count=1, re_d=1, `re`=1 every cycle.
- Backpressure: FIFO fills to 3 within 2 cycles; `re` stays 0 until occupancy allows; resumption restores 1 beat/cycle.
- `done`: registered, one cycle, never coincides with `out_valid`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `busy`=0 after release.
- Linear read: BRAM[i]=i+0x100, start base=4, count=8, ready=1 → beats 0x104..0x10B in cycles 3..10, `out_last` on 0x10B, `done` in cycle 11.
- Wrap: DEPTH=256, base=254, count=4 → addresses 254,255,0,1 in order, 4 beats, last on address 1's data.
- Backpressure: count=6, ready toggling 1,0,0,1,0,1… → exactly 6 beats, in order, no duplicates, `re` never asserted with fifo_count+re_d>2, data stable while stalled.
- Zero and full length: count=0 → no `re`, no beats, `done` one cycle later; count=256 → 256 beats then `done`.
- Reset during DRAIN with 2 words in FIFO → `out_valid`=0 immediately; next command count=2 returns only its own 2 words.
